// File: rtl/log_fifo_pkg.sv
// Shared constants and types for the firmware log FIFO and the AXI adapter log window.
package log_fifo_pkg;

  localparam int LOG_FIFO_ADDRW    = 32'd13;
  localparam int LOG_FIFO_DROPW    = 32'd16;
  localparam int LOG_FIFO_CAPACITY = (32'd2 ** LOG_FIFO_ADDRW) + 32'd1;

  typedef logic [7:0] log_char_t;

  localparam logic [15:0] LOG_WIN_DATA_OFFSET   = 16'h1000;
  localparam logic [15:0] LOG_WIN_STATUS_OFFSET = 16'h1004;

  // RAM entries plus the output head register.
  function automatic int log_fifo_capacity(input int addrw);
    return (32'd2 ** addrw) + 32'd1;
  endfunction

endpackage

// File: rtl/log_fifo_ram.sv
// Simple-dual-port byte RAM with registered read and no reset, shaped for BRAM inference.
module log_fifo_ram
  import log_fifo_pkg::*;
#(
  parameter int ADDRW = LOG_FIFO_ADDRW
) (
  input  logic             aclk,
  input  logic             we,
  input  logic [ADDRW-1:0] waddr,
  input  log_char_t        wdata,
  input  logic             re,
  input  logic [ADDRW-1:0] raddr,
  output log_char_t        rdata
);

  log_char_t mem_r [2**ADDRW];
  log_char_t rdata_r;

  // Write port and registered read port.
  always_ff @(posedge aclk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/log_fifo_fwft.sv
// First-word-fallthrough byte log FIFO: RAM backing store plus a one-entry head register,
// with a saturating dropped-character counter and sticky overflow flag.
module log_fifo_fwft
  import log_fifo_pkg::*;
#(
  parameter int ADDRW = LOG_FIFO_ADDRW,
  parameter int DROPW = LOG_FIFO_DROPW
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic             wr_en,
  input  log_char_t        wr_char,
  input  logic             fifo_rd,
  input  logic             drop_clr,
  output log_char_t        fifo_char,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic [DROPW-1:0] drop_cnt,
  output logic             overflow
);

  localparam logic [ADDRW+1:0] CAP      = (ADDRW+2)'(log_fifo_capacity(ADDRW));
  localparam logic [DROPW-1:0] DROP_MAX = {DROPW{1'b1}};

  logic             rst_meta_r, rst_sync_r;
  logic [ADDRW:0]   wr_ptr_r, rd_ptr_r;
  logic [ADDRW+1:0] occ_r, occ_nxt_s;
  logic             head_valid_r, head_valid_nxt_s, rd_pend_r;
  log_char_t        head_r, head_nxt_s, ram_rdata_s;
  logic             fifo_empty_r, fifo_full_r, overflow_r;
  logic [DROPW-1:0] drop_cnt_r;
  logic             wr_acc_s, drop_s, pop_s, bypass_s, ram_we_s, rd_issue_s, ram_nonempty_s;

  // Reset synchroniser: asserts immediately, releases two edges after rst falls.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      rst_meta_r <= 1'b1;
      rst_sync_r <= 1'b1;
    end else begin
      rst_meta_r <= 1'b0;
      rst_sync_r <= rst_meta_r;
    end
  end

  // Datapath decisions; bypass only when nothing (head, RAM, in-flight read) stays ahead of the write.
  always_comb begin
    wr_acc_s       = wr_en & ~fifo_full_r;
    drop_s         = wr_en & fifo_full_r;
    pop_s          = fifo_rd & head_valid_r;
    ram_nonempty_s = (wr_ptr_r != rd_ptr_r);
    bypass_s       = wr_acc_s & ((occ_r == {(ADDRW+2){1'b0}}) |
                                 ((occ_r == (ADDRW+2)'(1)) & pop_s));
    ram_we_s       = wr_acc_s & ~bypass_s;
    rd_issue_s     = ram_nonempty_s & ~rd_pend_r & (~head_valid_r | pop_s);

    occ_nxt_s = occ_r;
    if (wr_acc_s & ~pop_s) begin
      occ_nxt_s = occ_r + (ADDRW+2)'(1);
    end else if (~wr_acc_s & pop_s) begin
      occ_nxt_s = occ_r - (ADDRW+2)'(1);
    end else begin
      occ_nxt_s = occ_r;
    end

    head_valid_nxt_s = head_valid_r;
    head_nxt_s       = head_r;
    if (rd_pend_r) begin
      head_valid_nxt_s = 1'b1;
      head_nxt_s       = ram_rdata_s;
    end else if (bypass_s) begin
      head_valid_nxt_s = 1'b1;
      head_nxt_s       = wr_char;
    end else if (pop_s) begin
      head_valid_nxt_s = 1'b0;
    end else begin
      head_valid_nxt_s = head_valid_r;
    end
  end

  // Pointer, occupancy, head and status registers.
  always_ff @(posedge aclk or posedge rst_sync_r) begin
    if (rst_sync_r) begin
      wr_ptr_r     <= {(ADDRW+1){1'b0}};
      rd_ptr_r     <= {(ADDRW+1){1'b0}};
      occ_r        <= {(ADDRW+2){1'b0}};
      rd_pend_r    <= 1'b0;
      head_valid_r <= 1'b0;
      head_r       <= 8'h00;
      fifo_empty_r <= 1'b1;
      fifo_full_r  <= 1'b0;
      drop_cnt_r   <= {DROPW{1'b0}};
      overflow_r   <= 1'b0;
    end else begin
      if (ram_we_s) begin
        wr_ptr_r <= wr_ptr_r + (ADDRW+1)'(1);
      end
      if (rd_issue_s) begin
        rd_ptr_r <= rd_ptr_r + (ADDRW+1)'(1);
      end
      occ_r        <= occ_nxt_s;
      rd_pend_r    <= rd_issue_s;
      head_valid_r <= head_valid_nxt_s;
      head_r       <= head_nxt_s;
      fifo_empty_r <= ~head_valid_nxt_s;
      fifo_full_r  <= (occ_nxt_s == CAP);
      // A drop in the same cycle as a clear wins, leaving a count of one.
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_clr) begin
          drop_cnt_r <= DROPW'(1);
        end else if (drop_cnt_r != DROP_MAX) begin
          drop_cnt_r <= drop_cnt_r + DROPW'(1);
        end else begin
          drop_cnt_r <= drop_cnt_r;
        end
      end else if (drop_clr) begin
        overflow_r <= 1'b0;
        drop_cnt_r <= {DROPW{1'b0}};
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  log_fifo_ram #(.ADDRW(ADDRW)) u_ram (
    .aclk  (aclk),
    .we    (ram_we_s),
    .waddr (wr_ptr_r[ADDRW-1:0]),
    .wdata (wr_char),
    .re    (rd_issue_s),
    .raddr (rd_ptr_r[ADDRW-1:0]),
    .rdata (ram_rdata_s)
  );

  assign fifo_char  = head_r;
  assign fifo_empty = fifo_empty_r;
  assign fifo_full  = fifo_full_r;
  assign drop_cnt   = drop_cnt_r;
  assign overflow   = overflow_r;

endmodule
